fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined LEGv8 CPU. It is the producing end of the opcode interface: it generates the 11-bit opcode and instruction fields consumed by the control decoder. It also acts on the decoder's branch outputs (BrTaken, UncondBr, pc_rd) to redirect the PC, including the single architectural delay slot. It sits between the instruction memory and the register-read/decode stage.

Parameters:
ADDR_W, 64, width of PC and all address outputs
RESET_PC, 64'h0, PC value loaded on reset
HALT_WORD, 32'h14000000, instruction encoding (B #0) that ends fetch

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
imem_addr  out  ADDR_W  byte address presented to instruction memory; equals PC
imem_data  in  32  instruction word at imem_addr, combinational read
stall  in  1  hazard unit load-use stall; holds PC and IF/ID
br_taken  in  1  from decode: instruction currently in ID redirects the PC
uncond_br  in  1  from decode: selects imm26 (1) or imm19 (0) displacement
pc_rd  in  1  from decode: target is reg_rd_val (BR)
reg_rd_val  in  ADDR_W  Reg[Rd] read in ID, target for BR
id_instr  out  32  IF/ID instruction register
id_opcode  out  11  id_instr[31:21], drives the decoder opcode input
id_pc  out  ADDR_W  PC of id_instr
id_pc_plus4  out  ADDR_W  id_pc + 4; link value for BL into X30
id_valid  out  1  id_instr is a real fetched instruction
halted  out  1  fetch has stopped on HALT_WORD

Behaviour:
- FSM states: FILL, RUN, HALT. Reset (reset==0 at an edge): state=FILL, PC=RESET_PC, id_instr=32'h0, id_pc=0, id_valid=0, halted=0. id_pc_plus4 is then combinationally 4.
- FILL lasts exactly one cycle after reset deasserts. It captures imem_data at RESET_PC into IF/ID with id_valid=1, sets PC=RESET_PC+4, and moves to RUN. stall is ignored in FILL.
- RUN, stall=0: IF/ID <= {imem_data, PC}, id_valid=1, PC <= next_pc.
- next_pc:
  - br_taken=0: PC+4.
  - br_taken=1, pc_rd=1: {reg_rd_val[ADDR_W-1:2], 2'b00}.
  - br_taken=1, pc_rd=0, uncond_br=1: id_pc + sext(id_instr[25:0],2'b00).
  - br_taken=1, pc_rd=0, uncond_br=0: id_pc + sext(id_instr[23:5],2'b00).
  - pc_rd takes priority over uncond_br.
- Delay slot: the word fetched in the same cycle a redirect is taken (id_pc+4) is always latched into IF/ID and executes. It is never flushed. The target instruction enters ID one cycle after the delay slot.
- RUN, stall=1: PC, IF/ID and id_valid hold. Redirect is not applied. The branch stays in ID and takes effect in the first non-stalled cycle, using the br_taken value present then.
- HALT entry: in RUN with stall=0, if imem_data==HALT_WORD, the word is latched into IF/ID normally, PC holds, and state goes to HALT.
- HALT: PC held. IF/ID <= {32'h0, PC}, id_valid=0, halted=1. Stays in HALT until reset.
- A redirect pending in ID at the moment of HALT entry is still honoured only if it occurs in the same cycle; HALT_WORD in a delay slot still halts.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W. Wrap-around from 64'hFFFF_FFFF_FFFF_FFFC + 4 gives 0 with no flag. Displacements are sign-extended to ADDR_W before the add.
- Reset mid-operation overrides stall, br_taken and HALT. Everything returns to the reset values on that edge.
- Latency: imem_addr to id_opcode is one cycle. A redirect decided in ID reaches imem_addr on the next edge.

Test Plan:
- Reset, then 3 sequential ADDI words at 0,4,8 -> imem_addr 0,4,8,12 on successive cycles. id_pc 0,4,8. id_valid=0 only during reset. id_opcode=0x488/0x489 for each.
- B imm26=3 at PC 8, br_taken=1, uncond_br=1 in ID -> delay-slot word at 12 enters ID, then imem_addr=20 (8+12). id_pc sequence 8,12,20.
- CBZ imm19=-2 (0x7FFFE) at PC 16, br_taken=1, uncond_br=0 -> next imem_addr=8 after delay slot 20.
- BR with reg_rd_val=64'h103, pc_rd=1 at PC 4 -> imem_addr=64'h100. id_pc_plus4=8 while BR is in ID.
- BL in ID with stall=1 for 2 cycles, then stall=0 -> PC and IF/ID frozen for 2 cycles, redirect applied on the third edge, delay slot preserved.
- HALT_WORD at 12 -> halted=1 one cycle after it is latched. imem_addr stays 12, id_valid=0 thereafter. reset=0 mid-HALT -> imem_addr=0, halted=0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, decode feedback and the IF/ID register outputs.
// The fetch unit drives it through master; decode and memory connect through slave.
interface fetch_if #(
   parameter int ADDR_W = 64
);
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              stall;
   logic              br_taken;
   logic              uncond_br;
   logic              pc_rd;
   logic [ADDR_W-1:0] reg_rd_val;
   logic [31:0]       id_instr;
   logic [10:0]       id_opcode;
   logic [ADDR_W-1:0] id_pc;
   logic [ADDR_W-1:0] id_pc_plus4;
   logic              id_valid;
   logic              halted;

   modport master (
      output imem_addr, id_instr, id_opcode, id_pc, id_pc_plus4, id_valid, halted,
      input  imem_data, stall, br_taken, uncond_br, pc_rd, reg_rd_val
   );

   modport slave (
      input  imem_addr, id_instr, id_opcode, id_pc, id_pc_plus4, id_valid, halted,
      output imem_data, stall, br_taken, uncond_br, pc_rd, reg_rd_val
   );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch and IF/ID pipeline register with a single architectural delay slot.
//
// state  | meaning
// S_FILL | first cycle after reset: load the word at RESET_PC into IF/ID
// S_RUN  | normal fetch; honours stall and decode redirects
// S_HALT | HALT_WORD seen: PC frozen, IF/ID carries bubbles until reset
module fetch_unit #(
   parameter int                ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       HALT_WORD = 32'h1400_0000
) (
   input  logic   clk,
   input  logic   reset,
   fetch_if.master fif
);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       id_instr;
   logic [ADDR_W-1:0] id_pc;
   logic              id_valid;
   logic              halted;

   logic [ADDR_W-1:0] disp26;
   logic [ADDR_W-1:0] disp19;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] next_pc;
   logic              is_halt_word;

   // Displacements are word offsets; sign-extend after appending the two zero bits.
   assign disp26 = {{(ADDR_W-28){id_instr[25]}}, id_instr[25:0], 2'b00};
   assign disp19 = {{(ADDR_W-21){id_instr[23]}}, id_instr[23:5], 2'b00};

   always_comb begin
      branch_target = id_pc + disp19;
      if (fif.pc_rd) begin
         branch_target = fif.reg_rd_val & ~ADDR_W'(3);
      end else if (fif.uncond_br) begin
         branch_target = id_pc + disp26;
      end
   end

   assign next_pc      = fif.br_taken ? branch_target : pc + ADDR_W'(4);
   assign is_halt_word = (fif.imem_data == HALT_WORD);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_FILL;
         pc       <= RESET_PC;
         id_instr <= '0;
         id_pc    <= '0;
         id_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               id_instr <= fif.imem_data;
               id_pc    <= pc;
               id_valid <= 1'b1;
               pc       <= pc + ADDR_W'(4);
               state    <= S_RUN;
            end
            S_RUN: begin
               if (!fif.stall) begin
                  id_instr <= fif.imem_data;
                  id_pc    <= pc;
                  id_valid <= 1'b1;
                  if (is_halt_word) begin
                     // A redirect resolving in this same cycle still lands before the freeze.
                     pc    <= fif.br_taken ? branch_target : pc;
                     state <= S_HALT;
                  end else begin
                     pc <= next_pc;
                  end
               end
            end
            S_HALT: begin
               id_instr <= '0;
               id_pc    <= pc;
               id_valid <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state <= S_FILL;
            end
         endcase
      end
   end

   assign fif.imem_addr   = pc;
   assign fif.id_instr    = id_instr;
   assign fif.id_opcode   = id_instr[31:21];
   assign fif.id_pc       = id_pc;
   assign fif.id_pc_plus4 = id_pc + ADDR_W'(4);
   assign fif.id_valid    = id_valid;
   assign fif.halted      = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes model predictions, a monitor pops and compares.
module tb_fetch_unit;

   localparam logic [31:0] HALT = 32'h1400_0000;

   logic clk;
   logic reset;

   fetch_if #(.ADDR_W(64)) fif ();

   fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .HALT_WORD(HALT)) dut (
      .clk   (clk),
      .reset (reset),
      .fif   (fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] instr;
      logic [63:0] idpc;
      logic        valid;
      logic        halted;
   } exp_t;

   exp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   logic [31:0] mem [logic [63:0]];
   bit          rand_mode = 0;

   // Reference model: architectural view of fetch.
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic [63:0] m_idpc;
   logic        m_valid;
   logic        m_halted;
   bit          m_started;
   bit          m_stopped;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      if (rand_mode) return ($urandom_range(0, 30) == 0) ? HALT : $urandom;
      return 32'h9100_0000 | {20'h0, a[11:0]};
   endfunction

   function automatic logic [63:0] target_of(input bit ub, input bit prd, input logic [63:0] rrv);
      longint d;
      if (prd) return (rrv / 4) * 4;
      if (ub) begin
         d = longint'(m_instr[25:0]);
         if (d >= 2**25) d = d - 2**26;
      end else begin
         d = longint'(m_instr[23:5]);
         if (d >= 2**18) d = d - 2**19;
      end
      return m_idpc + 64'(d * 4);
   endfunction

   task automatic step(input bit r, input bit s, input bit bt, input bit ub,
                       input bit prd, input logic [63:0] rrv);
      logic [31:0] w;
      logic [63:0] tgt;
      exp_t e;
      reset          = r;
      fif.stall      = s;
      fif.br_taken   = bt;
      fif.uncond_br  = ub;
      fif.pc_rd      = prd;
      fif.reg_rd_val = rrv;
      w = word_at(m_pc);
      fif.imem_data = w;
      if (!r) begin
         m_pc = 64'h0; m_instr = 32'h0; m_idpc = 64'h0;
         m_valid = 1'b0; m_halted = 1'b0; m_started = 0; m_stopped = 0;
      end else if (!m_started) begin
         m_instr = w; m_idpc = m_pc; m_valid = 1'b1;
         m_pc = m_pc + 64'd4; m_started = 1;
      end else if (m_stopped) begin
         m_instr = 32'h0; m_idpc = m_pc; m_valid = 1'b0; m_halted = 1'b1;
      end else if (!s) begin
         tgt = target_of(ub, prd, rrv);
         m_instr = w; m_idpc = m_pc; m_valid = 1'b1;
         if (w == HALT) begin
            m_stopped = 1;
            if (bt) m_pc = tgt;
         end else begin
            m_pc = bt ? tgt : m_pc + 64'd4;
         end
      end
      e.addr = m_pc; e.instr = m_instr; e.idpc = m_idpc;
      e.valid = m_valid; e.halted = m_halted;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic go(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 64'h0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 64'h0);
      step(0, 1, 1, 1, 1, 64'hFFFF);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         chk("imem_addr",   fif.imem_addr,         e.addr);
         chk("id_instr",    64'(fif.id_instr),     64'(e.instr));
         chk("id_opcode",   64'(fif.id_opcode),    64'(e.instr[31:21]));
         chk("id_pc",       fif.id_pc,             e.idpc);
         chk("id_pc_plus4", fif.id_pc_plus4,       e.idpc + 64'd4);
         chk("id_valid",    64'(fif.id_valid),     64'(e.valid));
         chk("halted",      64'(fif.halted),       64'(e.halted));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      fif.stall = 0; fif.br_taken = 0; fif.uncond_br = 0; fif.pc_rd = 0;
      fif.reg_rd_val = '0; fif.imem_data = '0;
      @(negedge clk);

      // Sequential ADDIs then B imm26=3 at 8 with its delay slot at 12.
      mem[64'd0] = 32'h9100_0421;
      mem[64'd4] = 32'h9120_0842;
      mem[64'd8] = 32'h1400_0003;
      mem[64'd12] = 32'h9120_0C63;
      do_reset();
      step(1, 1, 0, 0, 0, 64'h0);      // stall ignored during fill
      go(2);
      step(1, 0, 1, 1, 0, 64'h0);
      go(2);

      // CBZ imm19=-2 at 16: delay slot 20, then back to 8.
      mem.delete();
      mem[64'd16] = 32'hB4FF_FFC0;
      do_reset();
      go(5);
      step(1, 0, 1, 0, 0, 64'h0);
      go(2);

      // BR X(rd)=0x103 at 4, then BL at 0x100 held by a 2-cycle stall.
      mem.delete();
      mem[64'd4]     = 32'hD61F_0000;
      mem[64'h100]   = 32'h9400_0004;
      do_reset();
      go(2);
      step(1, 0, 1, 1, 1, 64'h103);
      go(1);
      step(1, 1, 1, 1, 0, 64'h0);
      step(1, 1, 1, 1, 0, 64'h0);
      step(1, 0, 1, 1, 0, 64'h0);
      go(2);

      // PC wrap-around near the top of the address space.
      mem.delete();
      mem[64'd0] = 32'hD61F_0000;
      do_reset();
      step(1, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB);
      go(4);

      // HALT at 12, stall/branch noise while halted, reset mid-halt.
      mem.delete();
      mem[64'd12] = HALT;
      do_reset();
      go(4);
      step(1, 1, 1, 0, 1, 64'h40);
      step(1, 0, 1, 1, 0, 64'h0);
      go(2);
      step(0, 0, 0, 0, 0, 64'h0);
      go(3);

      // HALT_WORD in a delay slot: redirect lands, then fetch stops.
      mem.delete();
      mem[64'd8] = HALT;
      do_reset();
      go(1);
      step(1, 0, 1, 1, 1, 64'h200);
      go(3);

      // Randomized traffic.
      mem.delete();
      rand_mode = 1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bit r;
         r = ($urandom_range(0, 99) >= 2) && !(m_halted && $urandom_range(0, 9) == 0);
         step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, {$urandom, $urandom});
      end

      step(1, 0, 0, 0, 0, 64'h0);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
